vec_cond_sequencer: RTL
=======================

VEC_COND_SEQUENCER -- requirements
Module: vec_cond_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning elements processed per group (power of two).
REQ-002 SHALL have parameter MAXVL, default 16, meaning maximum vector length in elements (multiple of LANES).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, instruction valid from decode.
REQ-006 SHALL have port ready, output, 1, high when a start is accepted; accept = start & ready.
REQ-007 SHALL have port vl, input, $clog2(MAXVL)+1, vector length, sampled on accept.
REQ-008 SHALL have port flag_write, input, 2, FlagWrite request, sampled on accept; [1] = N/Z, [0] = C/V.
REQ-009 SHALL have port hold, input, 1, downstream stall; freezes group issue.
REQ-010 SHALL have port grp_valid, output, 1, a group is presented to the lanes this cycle.
REQ-011 SHALL have port elem_base, output, $clog2(MAXVL), index of the first element of the current group.
REQ-012 SHALL have port lane_mask, output, LANES, per-lane enable of the current group.
REQ-013 SHALL have port grp_flags, input, 4, {N,Z,C,V} of one completed group.
REQ-014 SHALL have port grp_flags_valid, input, 1, grp_flags valid; one pulse per issued group, in issue order.
REQ-015 SHALL have port flags_out, output, 4, accumulated {N,Z,C,V}.
REQ-016 SHALL have port flag_we, output, 2, per-half flag register write enable.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE, RUN, WAIT, DONE.
REQ-020 SHALL drive ready = 1 only in IDLE; start in any other state SHALL be ignored.
REQ-021 On accept with vl > 0, SHALL latch vl and flag_write, set issued = 0, returned = 0, accumulator = {0,1,0,0}, and go to RUN.
REQ-022 On accept with vl = 0, SHALL go directly to DONE with no group issued and flag_we = 0.
REQ-023 SHALL compute group count G = ceil(vl / LANES).
REQ-024 In RUN, SHALL drive grp_valid = ~hold, elem_base = issued*LANES, and lane_mask bit i = (elem_base + i < vl).
REQ-025 A group SHALL count as issued on a cycle with grp_valid = 1; issued then increments by 1.
REQ-026 When hold = 1, issued, elem_base and lane_mask SHALL hold their values.
REQ-027 After the G-th group issues, SHALL go to WAIT on the next edge; with no hold, groups issue on G consecutive cycles.
REQ-028 On each grp_flags_valid, in any state, SHALL update N |= N_g, Z &= Z_g, C |= C_g, V |= V_g, and increment returned.
REQ-029 SHALL leave WAIT for DONE in the cycle after returned reaches G; if returned reaches G while in RUN, SHALL go RUN -> WAIT -> DONE.
REQ-030 grp_flags_valid with returned = G, or in IDLE, SHALL be ignored.
REQ-031 In DONE, SHALL assert done = 1 and flag_we = latched flag_write for exactly one cycle, then go to IDLE.
REQ-032 flags_out SHALL equal the accumulator at all times and SHALL hold its value in IDLE until the next accept.
REQ-033 grp_valid, done and flag_we SHALL be 0 outside RUN and DONE as specified above.

Reset
REQ-034 On reset = 1, SHALL enter IDLE immediately, including mid-operation, with ready = 1 and busy = grp_valid = done = 0.
REQ-035 On reset = 1, SHALL drive flag_we = 0, flags_out = 0, elem_base = 0, lane_mask = 0, issued = returned = 0.
REQ-036 A reset during RUN or WAIT SHALL suppress done and flag_we for the aborted instruction.

Verification
REQ-037 vl=16, flag_write=11, no hold, all grp_flags=0100 returned 1 cycle after issue -> grp_valid on 4 consecutive cycles; elem_base 0,4,8,12; lane_mask 1111 each; done with flag_we=11 and flags_out=0100.
REQ-038 vl=6 -> 2 groups, lane_mask 1111 then 0011; group flags 0000 and 1010 -> flags_out=1010.
REQ-039 vl=8, hold=1 on the second RUN cycle -> elem_base stays 4 for 2 cycles; second group issues once; total 2 groups.
REQ-040 vl=0, flag_write=11 -> done 1 cycle after accept; flag_we=00; no grp_valid.
REQ-041 start while busy -> ignored; reset during RUN with vl=16 after 2 groups -> IDLE next cycle; no done; ready=1.
REQ-042 Flags returned with 3-cycle latency -> WAIT held until the 4th return; done exactly 1 cycle after it.

Source files
------------

// File: rtl/vec_cond_sequencer.sv
// Vector condition-code sequencer: splits a vl-element instruction into LANES-wide
// groups, issues them to the lanes, and folds the returned group flags into {N,Z,C,V}.
module vec_cond_sequencer #(
    parameter int LANES = 4,
    parameter int MAXVL = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       ready,
    input  logic [$clog2(MAXVL):0]     vl,
    input  logic [1:0]                 flag_write,
    input  logic                       hold,
    output logic                       grp_valid,
    output logic [$clog2(MAXVL)-1:0]   elem_base,
    output logic [LANES-1:0]           lane_mask,
    input  logic [3:0]                 grp_flags,
    input  logic                       grp_flags_valid,
    output logic [3:0]                 flags_out,
    output logic [1:0]                 flag_we,
    output logic                       busy,
    output logic                       done
);
    localparam int VW = $clog2(MAXVL) + 1;
    localparam int EW = $clog2(MAXVL);
    localparam int LW = $clog2(LANES);
    localparam int CW = VW + 1;

    typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;

    state_t        state;
    logic [VW-1:0] vl_q;
    logic [VW-1:0] grp_cnt;
    logic [VW-1:0] issued;
    logic [VW-1:0] returned;
    logic [1:0]    fw_q;
    logic [3:0]    acc;

    logic [CW-1:0] vl_round;
    logic [VW-1:0] grp_cnt_next;
    logic          ret_take;
    logic [VW-1:0] ret_next;
    logic          all_ret;

    // Group count rounds up so a partial trailing group still issues.
    assign vl_round     = CW'(vl) + CW'(LANES - 1);
    assign grp_cnt_next = VW'(vl_round >> LW);

    // Returns beyond the expected group count (or while idle) are dropped.
    assign ret_take = grp_flags_valid && (state != IDLE) && (returned != grp_cnt);
    assign ret_next = returned + VW'(ret_take);
    assign all_ret  = (ret_next == grp_cnt);

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign grp_valid = (state == RUN) && !hold;
    assign flags_out = acc;

    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign lane_mask[i] = (state == RUN) && ((CW'(elem_base) + CW'(i)) < CW'(vl_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vl_q      <= '0;
            grp_cnt   <= '0;
            issued    <= '0;
            returned  <= '0;
            fw_q      <= '0;
            acc       <= '0;
            elem_base <= '0;
            done      <= 1'b0;
            flag_we   <= 2'b00;
        end else begin
            if (ret_take) begin
                acc      <= {acc[3] | grp_flags[3], acc[2] & grp_flags[2],
                             acc[1] | grp_flags[1], acc[0] | grp_flags[0]};
                returned <= ret_next;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (vl != '0) begin
                            vl_q      <= vl;
                            grp_cnt   <= grp_cnt_next;
                            fw_q      <= flag_write;
                            issued    <= '0;
                            returned  <= '0;
                            acc       <= 4'b0100;
                            elem_base <= '0;
                            state     <= RUN;
                        end else begin
                            done    <= 1'b1;
                            flag_we <= 2'b00;
                            state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (!hold) begin
                        issued    <= issued + VW'(1);
                        elem_base <= elem_base + EW'(LANES);
                        if (issued + VW'(1) == grp_cnt)
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    // Finish the cycle after the last return lands.
                    if (all_ret) begin
                        done    <= 1'b1;
                        flag_we <= fw_q;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    flag_we <= 2'b00;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
